periph_bus_bridge: RTL and testbench
====================================

Name: periph_bus_bridge

Overview:
Parametrised, registered APB 1-to-NB_SLV demultiplexer for the SoC peripheral bus. It is the successor to the fixed-map peripheral bus wrapper. It takes one upstream APB request, decodes it against a runtime-programmable address map, and replays it as a full SETUP/ACCESS cycle on the selected downstream port. It adds three things the current bus lacks: an error response for unmapped addresses, a per-access PREADY watchdog, and error event pulses for the SoC event generator.

Parameters:
NB_SLV, 12, number of downstream APB ports (1..32)
ADDR_WIDTH, 32, APB address width
DATA_WIDTH, 32, APB data width
TIMEOUT_CYCLES, 256, max ACCESS cycles awaiting downstream PREADY; 0 disables the watchdog
ERR_DATA, 32'hBADACCE5, PRDATA returned on decode or timeout error (truncated to DATA_WIDTH)

Ports:
clk_i  in  1  single clock
rst_i  in  1  synchronous reset, active-high
paddr_i  in  ADDR_WIDTH  upstream address
pwdata_i  in  DATA_WIDTH  upstream write data
pwrite_i  in  1  upstream write strobe
psel_i  in  1  upstream select
penable_i  in  1  upstream enable
prdata_o  out  DATA_WIDTH  upstream read data
pready_o  out  1  upstream ready
pslverr_o  out  1  upstream error
start_addr_i  in  NB_SLV*ADDR_WIDTH  per-port region start, inclusive
end_addr_i  in  NB_SLV*ADDR_WIDTH  per-port region end, inclusive
m_paddr_o  out  ADDR_WIDTH  downstream address, shared by all ports
m_pwdata_o  out  DATA_WIDTH  downstream write data, shared
m_pwrite_o  out  1  downstream write strobe, shared
m_penable_o  out  1  downstream enable, shared
m_psel_o  out  NB_SLV  one-hot downstream select
m_prdata_i  in  NB_SLV*DATA_WIDTH  downstream read data
m_pready_i  in  NB_SLV  downstream ready
m_pslverr_i  in  NB_SLV  downstream error
decode_err_o  out  1  one-cycle pulse on an unmapped access
timeout_err_o  out  1  one-cycle pulse on a watchdog abort

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: state IDLE. All outputs 0, including prdata_o, m_paddr_o, m_pwdata_o and m_psel_o. The watchdog counter is cleared.
- A reset asserted mid-transaction forces m_psel_o and m_penable_o to 0 at the next edge. No response is issued.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - Accepts a request when psel_i & penable_i are both high.
  - Registers paddr_i, pwdata_i and pwrite_i, and the decode index.
  - Decode hit: go to SETUP. Decode miss: go to RESP with error.
- Decode rule: a port i hits when start_addr_i[i] <= addr <= end_addr_i[i]. With overlapping regions, the lowest index wins. Comparison is unsigned over the full ADDR_WIDTH.
- SETUP: m_psel_o[idx]=1, m_penable_o=0. Advance to ACCESS unconditionally.
- ACCESS:
  - m_psel_o[idx]=1, m_penable_o=1. The watchdog counts cycles spent in ACCESS.
  - On m_pready_i[idx]=1: register m_prdata_i[idx] and m_pslverr_i[idx], then go to RESP.
  - When the count reaches TIMEOUT_CYCLES without pready: drop psel/penable, set prdata=ERR_DATA and pslverr=1, pulse timeout_err_o, go to RESP.
  - If pready arrives on the same cycle the count expires, pready wins and there is no timeout.
- RESP:
  - pready_o=1 for exactly one cycle, with the registered prdata_o/pslverr_o. Then go to IDLE.
  - prdata_o holds its last value otherwise; it is only meaningful while pready_o=1.
- Decode miss: pslverr_o=1 and prdata_o=ERR_DATA. decode_err_o pulses in the same cycle as the RESP pready_o.
- Writes return prdata_o=0 on success.
- Latency, measured from the first upstream ACCESS cycle (cycle 0):
  - Zero-wait hit: pready_o at cycle 3.
  - Hit with W wait states: pready_o at cycle 3+W.
  - Miss: pready_o at cycle 1.
- The IDLE cycle after RESP is mandatory. A held psel_i&penable_i in IDLE is taken as a new request, so upstream must follow APB and drop penable after pready.
- Upstream abort (psel_i dropped mid-flight) is not checked. The downstream access completes and RESP still fires.
- m_paddr_o, m_pwdata_o and m_pwrite_o stay stable from SETUP through the last ACCESS cycle.
- The address map is sampled only in IDLE. Changing start/end inputs mid-transaction has no effect.

Decomposition:
- Package periph_bus_pkg holds:
  - the FSM state enum (bus_state_e);
  - the default ERR_DATA constant;
  - a helper function for the watchdog counter width, $clog2(TIMEOUT_CYCLES+1), with minimum 1.
- Sub-module apb_addr_decode (combinational) takes the address and map and outputs hit plus a binary index, using lowest-index priority.
- The bridge instantiates one apb_addr_decode. The FSM, watchdog and response registers stay in periph_bus_bridge.

Test Plan:
- Zero-wait read, map port 2 = 0x1A10_2000..0x1A10_2FFF: read 0x1A10_2004 with slave returning 0x1234_5678 -> m_psel_o=0b100 in SETUP/ACCESS; pready_o at cycle 3 with prdata_o=0x1234_5678, pslverr_o=0.
- Write with 4 wait states to port 0: m_pwdata_o is stable for 5 ACCESS cycles; pready_o at cycle 7; slave pslverr=1 -> pslverr_o=1.
- Unmapped address 0xFFFF_0000: no m_psel_o bit set; pready_o at cycle 1, pslverr_o=1, prdata_o=0xBADACCE5, decode_err_o pulses once.
- TIMEOUT_CYCLES=8, slave never ready: m_psel_o drops after 8 ACCESS cycles; pready_o=1, pslverr_o=1, timeout_err_o pulses. Repeat with pready arriving on cycle 8 -> normal completion, no timeout.
- Overlapping regions, ports 1 and 3 both covering 0x100: access 0x100 -> only m_psel_o[1] is set.
- rst_i asserted in ACCESS: next cycle m_psel_o=0, m_penable_o=0, pready_o=0; a following access completes normally.

Source files
------------

// File: rtl/periph_bus_pkg.sv
// Shared types and helpers for the peripheral APB bridge.
//   bus_state_e      : bridge FSM state encoding
//   ERR_DATA_DEFAULT : read data returned on decode miss or watchdog abort
//   wdog_cnt_width() : width of the ACCESS-cycle watchdog counter
//   idx_width()      : width of a binary downstream-port index
package periph_bus_pkg;

    typedef enum logic [1:0] {
        BUS_IDLE   = 2'd0,
        BUS_SETUP  = 2'd1,
        BUS_ACCESS = 2'd2,
        BUS_RESP   = 2'd3
    } bus_state_e;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hBADACCE5;

    // Counter must hold 0..timeout_cycles; never narrower than one bit so a
    // disabled watchdog (timeout_cycles == 0) still elaborates.
    function automatic int wdog_cnt_width(input int timeout_cycles);
        int w;
        w = $clog2(timeout_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational address decoder for the peripheral bridge.
//   addr_i       : address to decode
//   start_addr_i : packed per-port region starts (inclusive)
//   end_addr_i   : packed per-port region ends (inclusive)
//   hit_o        : some port's region contains addr_i
//   idx_o        : binary index of the matching port, lowest index wins
module apb_addr_decode
    import periph_bus_pkg::*;
#(
    parameter int NB_SLV     = 12,
    parameter int ADDR_WIDTH = 32,
    parameter int IDX_W      = idx_width(NB_SLV)
) (
    input  logic [ADDR_WIDTH-1:0]        addr_i,
    input  logic [NB_SLV*ADDR_WIDTH-1:0] start_addr_i,
    input  logic [NB_SLV*ADDR_WIDTH-1:0] end_addr_i,
    output logic                         hit_o,
    output logic [IDX_W-1:0]             idx_o
);

    // Walk from the highest port down so that the last assignment, i.e. the
    // lowest matching index, is the one that sticks on overlapping regions.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = NB_SLV - 1; i >= 0; i--) begin
            if ((addr_i >= start_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH]) &&
                (addr_i <= end_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                hit_o = 1'b1;
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/periph_bus_bridge.sv
// Registered APB 1-to-NB_SLV demultiplexer with a programmable address map.
// One upstream request is decoded in IDLE and replayed as a full SETUP/ACCESS
// cycle on the selected downstream port; unmapped addresses and downstream
// ports that never assert PREADY are answered with an error response.
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   paddr_i..penable_i           : upstream APB request
//   prdata_o, pready_o, pslverr_o: upstream APB response
//   start_addr_i, end_addr_i     : packed per-port address map (inclusive)
//   m_paddr_o..m_psel_o          : downstream APB request (psel one-hot)
//   m_prdata_i..m_pslverr_i      : downstream APB responses, per port
//   decode_err_o, timeout_err_o  : one-cycle error event pulses
module periph_bus_bridge
    import periph_bus_pkg::*;
#(
    parameter int          NB_SLV         = 12,
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 32,
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [ADDR_WIDTH-1:0]        paddr_i,
    input  logic [DATA_WIDTH-1:0]        pwdata_i,
    input  logic                         pwrite_i,
    input  logic                         psel_i,
    input  logic                         penable_i,
    output logic [DATA_WIDTH-1:0]        prdata_o,
    output logic                         pready_o,
    output logic                         pslverr_o,
    input  logic [NB_SLV*ADDR_WIDTH-1:0] start_addr_i,
    input  logic [NB_SLV*ADDR_WIDTH-1:0] end_addr_i,
    output logic [ADDR_WIDTH-1:0]        m_paddr_o,
    output logic [DATA_WIDTH-1:0]        m_pwdata_o,
    output logic                         m_pwrite_o,
    output logic                         m_penable_o,
    output logic [NB_SLV-1:0]            m_psel_o,
    input  logic [NB_SLV*DATA_WIDTH-1:0] m_prdata_i,
    input  logic [NB_SLV-1:0]            m_pready_i,
    input  logic [NB_SLV-1:0]            m_pslverr_i,
    output logic                         decode_err_o,
    output logic                         timeout_err_o
);

    localparam int IDX_W = idx_width(NB_SLV);
    localparam int CNT_W = wdog_cnt_width(TIMEOUT_CYCLES);
    // Counter value seen on the last ACCESS cycle that may still complete.
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [DATA_WIDTH-1:0] ERR_D = DATA_WIDTH'(ERR_DATA);

    bus_state_e            state_q,   state_d;
    logic [IDX_W-1:0]      idx_q,     idx_d;
    logic [ADDR_WIDTH-1:0] paddr_q,   paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q,  pwdata_d;
    logic                  pwrite_q,  pwrite_d;
    logic [DATA_WIDTH-1:0] prdata_q,  prdata_d;
    logic                  pslverr_q, pslverr_d;
    logic                  dec_err_q, dec_err_d;
    logic                  to_err_q,  to_err_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;

    logic                  dec_hit;
    logic [IDX_W-1:0]      dec_idx;
    logic                  sel_pready;
    logic                  sel_pslverr;
    logic [DATA_WIDTH-1:0] sel_prdata;
    logic                  wdog_expired;

    // The map is only consumed in IDLE, so later changes cannot disturb an
    // access already in flight.
    apb_addr_decode #(
        .NB_SLV     (NB_SLV),
        .ADDR_WIDTH (ADDR_WIDTH),
        .IDX_W      (IDX_W)
    ) u_decode (
        .addr_i       (paddr_i),
        .start_addr_i (start_addr_i),
        .end_addr_i   (end_addr_i),
        .hit_o        (dec_hit),
        .idx_o        (dec_idx)
    );

    assign sel_pready   = m_pready_i[idx_q];
    assign sel_pslverr  = m_pslverr_i[idx_q];
    assign sel_prdata   = m_prdata_i[idx_q*DATA_WIDTH +: DATA_WIDTH];
    assign wdog_expired = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        prdata_d  = prdata_q;
        pslverr_d = pslverr_q;
        dec_err_d = dec_err_q;
        to_err_d  = to_err_q;
        cnt_d     = cnt_q;
        case (state_q)
            BUS_IDLE: begin
                if (psel_i && penable_i) begin
                    paddr_d   = paddr_i;
                    pwdata_d  = pwdata_i;
                    pwrite_d  = pwrite_i;
                    idx_d     = dec_idx;
                    cnt_d     = '0;
                    dec_err_d = !dec_hit;
                    to_err_d  = 1'b0;
                    if (dec_hit) begin
                        state_d = BUS_SETUP;
                    end else begin
                        prdata_d  = ERR_D;
                        pslverr_d = 1'b1;
                        state_d   = BUS_RESP;
                    end
                end
            end
            BUS_SETUP: begin
                cnt_d   = '0;
                state_d = BUS_ACCESS;
            end
            BUS_ACCESS: begin
                // PREADY is checked before the watchdog so a response on the
                // final allowed cycle completes normally.
                if (sel_pready) begin
                    prdata_d  = pwrite_q ? '0 : sel_prdata;
                    pslverr_d = sel_pslverr;
                    state_d   = BUS_RESP;
                end else if (wdog_expired) begin
                    prdata_d  = ERR_D;
                    pslverr_d = 1'b1;
                    to_err_d  = 1'b1;
                    state_d   = BUS_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BUS_RESP: begin
                state_d = BUS_IDLE;
            end
            default: begin
                state_d = BUS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= BUS_IDLE;
            idx_q     <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            dec_err_q <= 1'b0;
            to_err_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            dec_err_q <= dec_err_d;
            to_err_q  <= to_err_d;
            cnt_q     <= cnt_d;
        end
    end

    // All handshake outputs decode straight from state flops; the error
    // flags are qualified by RESP so they pulse exactly with pready_o.
    always_comb begin
        m_psel_o = '0;
        if ((state_q == BUS_SETUP) || (state_q == BUS_ACCESS)) begin
            m_psel_o[idx_q] = 1'b1;
        end
    end

    assign m_penable_o   = (state_q == BUS_ACCESS);
    assign m_paddr_o     = paddr_q;
    assign m_pwdata_o    = pwdata_q;
    assign m_pwrite_o    = pwrite_q;
    assign pready_o      = (state_q == BUS_RESP);
    assign prdata_o      = prdata_q;
    assign pslverr_o     = pready_o & pslverr_q;
    assign decode_err_o  = pready_o & dec_err_q;
    assign timeout_err_o = pready_o & to_err_q;

endmodule

// File: tb/tb_periph_bus_bridge.sv
// Self-checking bench for periph_bus_bridge: directed cases from the test
// plan followed by random transactions scored against a transaction-level
// model (region lookup, latency formula, expected response).
module tb_periph_bus_bridge;

    localparam int NB = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;
    localparam logic [31:0] ERR = 32'hBADACCE5;

    logic           clk = 1'b0;
    logic           rst_i;
    logic [AW-1:0]  paddr_i;
    logic [DW-1:0]  pwdata_i;
    logic           pwrite_i, psel_i, penable_i;
    logic [DW-1:0]  prdata_o;
    logic           pready_o, pslverr_o;
    logic [NB*AW-1:0] start_addr_i, end_addr_i;
    logic [AW-1:0]  m_paddr_o;
    logic [DW-1:0]  m_pwdata_o;
    logic           m_pwrite_o, m_penable_o;
    logic [NB-1:0]  m_psel_o;
    logic [NB*DW-1:0] m_prdata_i;
    logic [NB-1:0]  m_pready_i, m_pslverr_i;
    logic           decode_err_o, timeout_err_o;

    logic [AW-1:0]  st [NB];
    logic [AW-1:0]  en [NB];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NB; g++) begin : g_map
        assign start_addr_i[g*AW +: AW] = st[g];
        assign end_addr_i[g*AW +: AW]   = en[g];
    end

    periph_bus_bridge #(
        .NB_SLV(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .paddr_i(paddr_i), .pwdata_i(pwdata_i), .pwrite_i(pwrite_i),
        .psel_i(psel_i), .penable_i(penable_i),
        .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
        .start_addr_i(start_addr_i), .end_addr_i(end_addr_i),
        .m_paddr_o(m_paddr_o), .m_pwdata_o(m_pwdata_o), .m_pwrite_o(m_pwrite_o),
        .m_penable_o(m_penable_o), .m_psel_o(m_psel_o),
        .m_prdata_i(m_prdata_i), .m_pready_i(m_pready_i), .m_pslverr_i(m_pslverr_i),
        .decode_err_o(decode_err_o), .timeout_err_o(timeout_err_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference lookup: first region (in port order) containing the address.
    function automatic void ref_decode(input logic [31:0] a, output bit hit, output int idx);
        hit = 1'b0;
        idx = 0;
        for (int i = 0; i < NB; i++) begin
            if (!hit && st[i] <= a && a <= en[i]) begin
                hit = 1'b1;
                idx = i;
            end
        end
    endfunction

    // One upstream APB transfer. w = wait states the selected slave inserts
    // before PREADY (w >= TO means it never answers inside the watchdog).
    task automatic do_xfer(input string nm, input logic [31:0] a, input bit wr,
                           input logic [31:0] wd, input int w,
                           input logic [31:0] srd, input bit serr);
        bit hit;
        int idx, exp_lat, cyc, acc, lat, dec_p, to_p, bad_sel, unstable;
        logic [31:0] exp_rd;
        bit exp_err, exp_to;
        logic [NB-1:0] exp_sel;
        ref_decode(a, hit, idx);
        if (!hit) begin
            exp_lat = 1; exp_rd = ERR; exp_err = 1'b1; exp_to = 1'b0;
        end else if (w >= TO) begin
            exp_lat = 2 + TO; exp_rd = ERR; exp_err = 1'b1; exp_to = 1'b1;
        end else begin
            exp_lat = 3 + w; exp_rd = wr ? 32'h0 : srd; exp_err = serr; exp_to = 1'b0;
        end
        // Non-selected ports answer instantly with other data, so a wrong
        // port choice shows up as wrong latency or data.
        for (int i = 0; i < NB; i++) begin
            m_prdata_i[i*DW +: DW] = (hit && i == idx) ? srd : ~srd ^ $urandom;
            m_pslverr_i[i]         = (hit && i == idx) ? serr : ~serr;
            m_pready_i[i]          = !(hit && i == idx);
        end
        @(negedge clk);
        paddr_i = a; pwdata_i = wd; pwrite_i = wr; psel_i = 1'b1; penable_i = 1'b0;
        @(negedge clk);
        penable_i = 1'b1;
        cyc = 0; acc = 0; lat = -1; dec_p = 0; to_p = 0; bad_sel = 0; unstable = 0;
        while (lat < 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            exp_sel = (hit && cyc < exp_lat) ? (NB'(1) << idx) : '0;
            if (m_psel_o !== exp_sel) bad_sel++;
            if (m_penable_o !== (hit && cyc >= 2 && cyc < exp_lat)) bad_sel++;
            if (m_penable_o) begin
                acc++;
                if (m_paddr_o !== a || m_pwdata_o !== wd || m_pwrite_o !== wr) unstable++;
            end
            dec_p += int'(decode_err_o);
            to_p  += int'(timeout_err_o);
            if (pready_o) begin
                lat = cyc;
                check({nm, " prdata"}, prdata_o, exp_rd);
                check({nm, " pslverr"}, pslverr_o, exp_err);
                psel_i = 1'b0; penable_i = 1'b0;
            end else if (hit) begin
                m_pready_i[idx] = m_penable_o && (acc == w + 1);
            end
        end
        check({nm, " latency"}, lat, exp_lat);
        check({nm, " select/enable"}, bad_sel, 0);
        check({nm, " addr/data stable"}, unstable, 0);
        check({nm, " access cycles"}, acc, hit ? exp_lat - 2 : 0);
        @(negedge clk);
        dec_p += int'(decode_err_o);
        to_p  += int'(timeout_err_o);
        check({nm, " ready drops"}, pready_o, 0);
        check({nm, " decode_err pulses"}, dec_p, !hit);
        check({nm, " timeout_err pulses"}, to_p, exp_to);
    endtask

    initial begin
        int ok;
        st[0] = 32'h0000_1000; en[0] = 32'h0000_1FFF;
        st[1] = 32'h0000_0100; en[1] = 32'h0000_01FF;
        st[2] = 32'h1A10_2000; en[2] = 32'h1A10_2FFF;
        st[3] = 32'h0000_0000; en[3] = 32'h0000_0FFF;
        rst_i = 1'b1; paddr_i = '0; pwdata_i = '0; pwrite_i = 1'b0;
        psel_i = 1'b0; penable_i = 1'b0;
        m_prdata_i = '0; m_pready_i = '0; m_pslverr_i = '0;
        repeat (3) @(negedge clk);
        check("reset pready", pready_o, 0);
        check("reset pslverr", pslverr_o, 0);
        check("reset prdata", prdata_o, 0);
        check("reset psel", m_psel_o, 0);
        check("reset penable", m_penable_o, 0);
        check("reset maddr", m_paddr_o, 0);
        check("reset mwdata", m_pwdata_o, 0);
        check("reset errs", {decode_err_o, timeout_err_o}, 0);
        rst_i = 1'b0;

        do_xfer("zero-wait read", 32'h1A10_2004, 1'b0, 32'h0, 0, 32'h1234_5678, 1'b0);
        do_xfer("write 4 waits", 32'h0000_1004, 1'b1, 32'hCAFE_F00D, 4, 32'h5555_AAAA, 1'b1);
        do_xfer("unmapped", 32'hFFFF_0000, 1'b0, 32'h0, 0, 32'h0, 1'b0);
        do_xfer("watchdog", 32'h1A10_2100, 1'b0, 32'h0, 100, 32'h7777_0000, 1'b0);
        do_xfer("ready at limit", 32'h1A10_2200, 1'b0, 32'h0, TO - 1, 32'h0BAD_F00D, 1'b0);
        do_xfer("overlap", 32'h0000_0100, 1'b0, 32'h0, 1, 32'h0000_0101, 1'b0);
        do_xfer("port3 low edge", 32'h0000_0000, 1'b0, 32'h0, 0, 32'h3333_0000, 1'b1);
        do_xfer("port2 high edge", 32'h1A10_2FFF, 1'b1, 32'h1111_2222, 2, 32'h0, 1'b0);
        do_xfer("just past port2", 32'h1A10_3000, 1'b1, 32'h1, 0, 32'h0, 1'b0);

        // Reset in the middle of ACCESS.
        for (int i = 0; i < NB; i++) m_pready_i[i] = 1'b0;
        @(negedge clk);
        paddr_i = 32'h1A10_2010; pwrite_i = 1'b0; psel_i = 1'b1; penable_i = 1'b0;
        @(negedge clk);
        penable_i = 1'b1;
        ok = 0;
        for (int c = 0; c < 10 && ok < 2; c++) begin
            @(negedge clk);
            if (m_penable_o) ok++;
        end
        check("reached access", ok, 2);
        rst_i = 1'b1; psel_i = 1'b0; penable_i = 1'b0;
        @(negedge clk);
        check("mid-reset psel", m_psel_o, 0);
        check("mid-reset penable", m_penable_o, 0);
        check("mid-reset pready", pready_o, 0);
        check("mid-reset prdata", prdata_o, 0);
        rst_i = 1'b0;
        do_xfer("after reset", 32'h1A10_2010, 1'b0, 32'h0, 1, 32'h2468_ACE0, 1'b0);

        for (int n = 0; n < 25; n++) begin
            int p;
            logic [31:0] a;
            p = $urandom_range(0, 4);
            if (p < NB) a = st[p] + ($urandom % (en[p] - st[p] + 1));
            else a = $urandom;
            do_xfer($sformatf("rand%0d", n), a, 1'($urandom), $urandom,
                    $urandom_range(0, TO + 1), $urandom, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
